controlador_de_interrupcao: RTL and testbench

- Initiator side of the CPU interrupt handshake: collects peripheral interrupt lines, raises `intr` to the control unit, and waits for `inta`.
- On `inta`, latches the winning source into `cause`, so the handler can read it after the program counter saves its backup address and vectors to 0.
- Holds further requests pending until the return-from-interrupt sequence pulses `eoi`.

---
 rtl/izero_int_pkg.sv | 14 +
 rtl/int_prio_enc.sv | 23 ++
 rtl/controlador_de_interrupcao.sv | 140 ++++++++++++++
 tb/tb_controlador_de_interrupcao.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/izero_int_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// default sizing of the request vector and cause index.
package izero_int_pkg;

  localparam int DEF_N_IRQ   = 8;
  localparam int DEF_CAUSE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit (index 0 has the highest priority).
module int_prio_enc
  import izero_int_pkg::*;
#(
  parameter int N_IRQ   = DEF_N_IRQ,
  parameter int CAUSE_W = DEF_CAUSE_W
) (
  input  logic [N_IRQ-1:0]   vec,
  output logic               valid,
  output logic [CAUSE_W-1:0] idx
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller: edge-latches peripheral requests, raises intr, records
// the winning source on inta and blocks new requests until eoi. Optional
// input synchronizer enabled with `define IRQ_SYNC_EN.
module controlador_de_interrupcao
  import izero_int_pkg::*;
#(
  parameter int N_IRQ   = DEF_N_IRQ,
  parameter int CAUSE_W = DEF_CAUSE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               mask_we,
  input  logic [N_IRQ-1:0]   mask_in,
  input  logic               inta,
  input  logic               eoi,
  output logic               intr,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_service,
  output logic [N_IRQ-1:0]   pending
);

  state_t             state_reg, state_next;
  logic               intr_reg, intr_next;
  logic               in_service_reg, in_service_next;
  logic [CAUSE_W-1:0] cause_reg, cause_next;
  logic [N_IRQ-1:0]   pending_reg, pending_next;
  logic [N_IRQ-1:0]   pending_clr;
  logic [N_IRQ-1:0]   mask_reg;
  logic [N_IRQ-1:0]   irq_q;
  logic [N_IRQ-1:0]   irq_src;
  logic [N_IRQ-1:0]   irq_rise;
  logic [N_IRQ-1:0]   active;
  logic               win_valid;
  logic [CAUSE_W-1:0] win_idx;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_src = sync2_reg;
`else
  assign irq_src = irq;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_edge
      assign irq_rise[gi]     = irq_src[gi] & ~irq_q[gi];
      // A fresh edge beats an acknowledge clear in the same cycle.
      assign pending_next[gi] = (pending_reg[gi] & ~pending_clr[gi]) | irq_rise[gi];
    end
  endgenerate

  assign active = pending_reg & mask_reg;

  int_prio_enc #(
    .N_IRQ   (N_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio (
    .vec   (active),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      intr_reg       <= 1'b0;
      in_service_reg <= 1'b0;
      cause_reg      <= '0;
      pending_reg    <= '0;
      mask_reg       <= '0;
      irq_q          <= '0;
    end else begin
      state_reg      <= state_next;
      intr_reg       <= intr_next;
      in_service_reg <= in_service_next;
      cause_reg      <= cause_next;
      pending_reg    <= pending_next;
      irq_q          <= irq_src;
      if (mask_we) mask_reg <= mask_in;
    end
  end

  always_comb begin
    state_next      = state_reg;
    intr_next       = intr_reg;
    in_service_next = in_service_reg;
    cause_next      = cause_reg;
    pending_clr     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          state_next = ST_REQ;
          intr_next  = 1'b1;
        end
      end
      ST_REQ: begin
        // Winner is re-evaluated here, so a late higher-priority source wins.
        if (inta && win_valid) begin
          cause_next           = win_idx;
          pending_clr[win_idx] = 1'b1;
          intr_next            = 1'b0;
          in_service_next      = 1'b1;
          state_next           = ST_SERVICE;
        end else if (!win_valid) begin
          intr_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          in_service_next = 1'b0;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next      = ST_IDLE;
        intr_next       = 1'b0;
        in_service_next = 1'b0;
      end
    endcase
  end

  assign intr       = intr_reg;
  assign cause      = cause_reg;
  assign in_service = in_service_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Directed bench for controlador_de_interrupcao: walks the interrupt handshake
// through hand-computed scenarios and prints one line per check.
module tb_controlador_de_interrupcao;

  logic       clk;
  logic       reset;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [2:0] cause;
  logic       in_service;
  logic [7:0] pending;

  int n_tests;
  int n_failed;

  controlador_de_interrupcao dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .inta       (inta),
    .eoi        (eoi),
    .intr       (intr),
    .cause      (cause),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset    = 1'b1;
    irq      = '0;
    mask_we  = 1'b0;
    mask_in  = '0;
    inta     = 1'b0;
    eoi      = 1'b0;
    tick();
    tick();
    check_val("rst_intr", 32'(intr), 32'd0);
    check_val("rst_cause", 32'(cause), 32'd0);
    check_val("rst_insvc", 32'(in_service), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    tick();

    // Single source, full mask.
    write_mask(8'hFF);
    irq = 8'h20; tick();
    check_val("s1_pending", 32'(pending), 32'h20);
    check_val("s1_intr_early", 32'(intr), 32'd0);
    irq = 8'h00; tick();
    check_val("s1_intr", 32'(intr), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s1_cause", 32'(cause), 32'd5);
    check_val("s1_insvc", 32'(in_service), 32'd1);
    check_val("s1_intr_ack", 32'(intr), 32'd0);
    check_val("s1_pending_ack", 32'(pending), 32'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check_val("s1_insvc_eoi", 32'(in_service), 32'd0);
    check_val("s1_cause_hold", 32'(cause), 32'd5);
    tick();
    check_val("s1_idle_intr", 32'(intr), 32'd0);

    // Two simultaneous sources: lowest index first, then back-to-back.
    irq = 8'h44; tick();
    check_val("s2_pending", 32'(pending), 32'h44);
    irq = 8'h00; tick();
    check_val("s2_intr", 32'(intr), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s2_cause_a", 32'(cause), 32'd2);
    check_val("s2_pending_a", 32'(pending), 32'h40);
    tick();
    check_val("s2_svc_intr", 32'(intr), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check_val("s2_eoi_intr", 32'(intr), 32'd0);
    tick();
    check_val("s2_reraise", 32'(intr), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s2_cause_b", 32'(cause), 32'd6);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Masked event stays pending until the mask opens.
    write_mask(8'h00);
    irq = 8'h08; tick();
    check_val("s3_pending", 32'(pending), 32'h08);
    irq = 8'h00; tick(); tick();
    check_val("s3_masked_intr", 32'(intr), 32'd0);
    write_mask(8'h08);
    check_val("s3_intr_w0", 32'(intr), 32'd0);
    tick();
    check_val("s3_intr_w1", 32'(intr), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s3_cause", 32'(cause), 32'd3);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Events during service accumulate without raising intr.
    write_mask(8'hFF);
    irq = 8'h02; tick();
    irq = 8'h00; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s4_cause", 32'(cause), 32'd1);
    irq = 8'h11; tick();
    irq = 8'h00; tick();
    check_val("s4_svc_intr", 32'(intr), 32'd0);
    check_val("s4_pending", 32'(pending), 32'h11);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check_val("s4_intr", 32'(intr), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s4_cause0", 32'(cause), 32'd0);
    check_val("s4_pending_left", 32'(pending), 32'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s4_cause4", 32'(cause), 32'd4);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Higher-priority source arriving during REQ wins the acknowledge.
    irq = 8'h20; tick();
    irq = 8'h00; tick();
    irq = 8'h02; tick();
    check_val("s5_pending", 32'(pending), 32'h22);
    check_val("s5_intr_hold", 32'(intr), 32'd1);
    irq = 8'h00;
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s5_cause", 32'(cause), 32'd1);
    check_val("s5_pending_ack", 32'(pending), 32'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s5_cause5", 32'(cause), 32'd5);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // eoi in REQ is ignored; new edge in the acknowledge cycle wins over clear.
    irq = 8'h04; tick();
    irq = 8'h00; tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    check_val("s6_eoi_req_intr", 32'(intr), 32'd1);
    check_val("s6_eoi_req_insvc", 32'(in_service), 32'd0);
    irq = 8'h04; inta = 1'b1; tick(); inta = 1'b0; irq = 8'h00;
    check_val("s6_cause", 32'(cause), 32'd2);
    check_val("s6_set_wins", 32'(pending), 32'h04);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s6_cause2", 32'(cause), 32'd2);
    check_val("s6_pending0", 32'(pending), 32'h00);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Mask withdrawn while in REQ.
    irq = 8'h80; tick();
    irq = 8'h00; tick();
    check_val("s7_intr", 32'(intr), 32'd1);
    write_mask(8'h00);
    tick();
    check_val("s7_intr_drop", 32'(intr), 32'd0);
    check_val("s7_pending", 32'(pending), 32'h80);
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s7_inta_idle", 32'(in_service), 32'd0);
    check_val("s7_cause_hold", 32'(cause), 32'd2);

    // Asynchronous reset mid-service.
    write_mask(8'hFF);
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    check_val("s8_cause7", 32'(cause), 32'd7);
    irq = 8'h0C; tick();
    irq = 8'h00;
    check_val("s8_pending", 32'(pending), 32'h0C);
    check_val("s8_insvc", 32'(in_service), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("s8_async_insvc", 32'(in_service), 32'd0);
    check_val("s8_async_pending", 32'(pending), 32'h00);
    check_val("s8_async_cause", 32'(cause), 32'd0);
    check_val("s8_async_intr", 32'(intr), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check_val("s8_post_intr", 32'(intr), 32'd0);
    check_val("s8_post_insvc", 32'(in_service), 32'd0);
    check_val("s8_post_cause", 32'(cause), 32'd0);
    check_val("s8_post_pending", 32'(pending), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
